// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU-op classes and datapath mux selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_ALU = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_CMP   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_A_PC     = 2'd0,
        SRC_A_OLD_PC = 2'd1,
        SRC_A_RS1    = 2'd2
    } src_a_t;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'd0,
        SRC_B_FOUR = 2'd1,
        SRC_B_IMM  = 2'd2
    } src_b_t;

    typedef enum logic [1:0] {
        WB_ALUOUT   = 2'd0,
        WB_MEM_DATA = 2'd1,
        WB_PC4      = 2'd2
    } wb_sel_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_IMM,
        CLS_MEM,
        CLS_BRANCH,
        CLS_JAL,
        CLS_ILLEGAL
    } op_class_t;

endpackage

// File: rtl/ctrl_opcode_class.sv
// Combinational opcode classifier used by DECODE to pick the execute path.
// JAL is recognised only when MULTICYCLE_CTRL_JAL_EN is defined.
module ctrl_opcode_class
    import ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output op_class_t  o_class
);

    always_comb begin
        case (i_opcode)
            OP_R:      o_class = CLS_R;
            OP_IMM:    o_class = CLS_IMM;
            OP_LOAD:   o_class = CLS_MEM;
            OP_STORE:  o_class = CLS_MEM;
            OP_BRANCH: o_class = CLS_BRANCH;
`ifdef MULTICYCLE_CTRL_JAL_EN
            OP_JAL:    o_class = CLS_JAL;
`else
            OP_JAL:    o_class = CLS_ILLEGAL;
`endif
            default:   o_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM with opcode latch and retired-instruction counter.
// Optional JAL support is enabled by defining MULTICYCLE_CTRL_JAL_EN.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [6:0]         i_opcode,
    input  logic               i_mem_ready,
    input  logic               i_branch_taken,
    output logic               o_pc_write,
    output logic               o_pc_src,
    output logic               o_ir_write,
    output logic               o_mem_iord,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic [1:0]         o_alu_src_a,
    output logic [1:0]         o_alu_src_b,
    output logic [ALUOP_W-1:0] o_alu_op,
    output logic               o_reg_write,
    output logic [1:0]         o_wb_sel,
    output logic               o_illegal,
    output logic [CNT_W-1:0]   o_retired
);

    state_t           state_q, state_d;
    logic [6:0]       opcode_q;
    logic [CNT_W-1:0] retired_q;
    op_class_t        op_class;
    logic             retire;
    alu_op_t          alu_op;
    src_a_t           src_a;
    src_b_t           src_b;
    wb_sel_t          wb_sel;

    ctrl_opcode_class u_opcode_class (
        .i_opcode (i_opcode),
        .o_class  (op_class)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // ADDR chooses load vs store from this copy; the IR may change after DECODE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                  opcode_q <= '0;
        else if (state_q == S_DECODE)  opcode_q <= i_opcode;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    retired_q <= '0;
        else if (retire) retired_q <= retired_q + CNT_W'(1);
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave a value held and infer a latch.
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        o_pc_write  = 1'b0;
        o_pc_src    = 1'b0;
        o_ir_write  = 1'b0;
        o_mem_iord  = 1'b0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        o_reg_write = 1'b0;
        o_illegal   = 1'b0;
        src_a       = SRC_A_PC;
        src_b       = SRC_B_RS2;
        alu_op      = ALU_ADD;
        wb_sel      = WB_ALUOUT;

        case (state_q)
            S_FETCH: begin
                o_mem_read = 1'b1;
                src_b      = SRC_B_FOUR;
                if (i_mem_ready) begin
                    // Reset holds the FSM here; keep the IR and PC untouched.
                    o_ir_write = i_rst_n;
                    o_pc_write = i_rst_n;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                src_a = SRC_A_OLD_PC;
                src_b = SRC_B_IMM;
                case (op_class)
                    CLS_R:      state_d = S_EXEC_R;
                    CLS_IMM:    state_d = S_EXEC_I;
                    CLS_MEM:    state_d = S_ADDR;
                    CLS_BRANCH: state_d = S_BRANCH;
`ifdef MULTICYCLE_CTRL_JAL_EN
                    CLS_JAL:    state_d = S_JUMP;
`endif
                    default:    state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                src_a   = SRC_A_RS1;
                src_b   = SRC_B_RS2;
                alu_op  = ALU_FUNCT;
                state_d = S_WB_ALU;
            end
            S_EXEC_I: begin
                src_a   = SRC_A_RS1;
                src_b   = SRC_B_IMM;
                alu_op  = ALU_FUNCT;
                state_d = S_WB_ALU;
            end
            S_ADDR: begin
                src_a   = SRC_A_RS1;
                src_b   = SRC_B_IMM;
                state_d = (opcode_q == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                o_mem_read = 1'b1;
                o_mem_iord = 1'b1;
                if (i_mem_ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                o_mem_write = 1'b1;
                o_mem_iord  = 1'b1;
                if (i_mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_WB_ALU: begin
                o_reg_write = 1'b1;
                wb_sel      = WB_ALUOUT;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_WB_MEM: begin
                o_reg_write = 1'b1;
                wb_sel      = WB_MEM_DATA;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                src_a      = SRC_A_RS1;
                src_b      = SRC_B_RS2;
                alu_op     = ALU_CMP;
                o_pc_src   = 1'b1;
                o_pc_write = i_branch_taken;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
`ifdef MULTICYCLE_CTRL_JAL_EN
            S_JUMP: begin
                o_reg_write = 1'b1;
                wb_sel      = WB_PC4;
                o_pc_write  = 1'b1;
                o_pc_src    = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
`endif
            S_TRAP: begin
                o_illegal = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        o_alu_op      = '0;
        o_alu_op[1:0] = alu_op;
    end

    assign o_alu_src_a = src_a;
    assign o_alu_src_b = src_b;
    assign o_wb_sel    = wb_sel;
    assign o_retired   = retired_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control unit for the RV32I datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states over a shared instruction/data memory with a ready handshake. It generalises the single-cycle opcode decoder into an FSM with configurable ALU-op width and an instruction-retire counter. It sits between the instruction register and the datapath muxes, PC, register file and memory port.

## Interface
- ALUOP_W, 2, width of o_alu_op (00 add, 01 compare/branch, 10 funct-decoded; upper bits zero).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- i_opcode  in  7  instruction-register opcode field.
- i_mem_ready  in  1  memory completes the current read or write this cycle.
- i_branch_taken  in  1  ALU comparison result, valid in BRANCH.
- o_pc_write  out  1  PC load enable.
- o_pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut register.
- o_ir_write  out  1  instruction register load.
- o_mem_iord  out  1  memory address source: 0 = PC, 1 = ALUOut.
- o_mem_read  out  1  memory read request.
- o_mem_write  out  1  memory write request.
- o_alu_src_a  out  2  ALU A input: 0 = PC, 1 = old PC, 2 = rs1.
- o_alu_src_b  out  2  ALU B input: 0 = rs2, 1 = constant 4, 2 = immediate.
- o_alu_op  out  ALUOP_W  ALU operation class.
- o_reg_write  out  1  register-file write enable.
- o_wb_sel  out  2  writeback source: 0 = ALUOut, 1 = memory data, 2 = PC+4.
- o_illegal  out  1  sticky flag for an unsupported opcode.
- o_retired  out  CNT_W  count of completed instructions.

## Operation
States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, TRAP.

- **FETCH:** mem_read=1, iord=0, src_a=0, src_b=1, alu_op=00.
  - While i_mem_ready is high: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - While i_mem_ready is low: hold in FETCH with ir_write=0 and pc_write=0.
- **DECODE:** src_a=1, src_b=2, alu_op=00; this computes the branch/jump target into ALUOut. Next state by i_opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → ADDR
  - 1100011 → BRANCH
  - 1101111 → JUMP (only when the macro is defined)
  - any other opcode → TRAP
- **EXEC_R:** src_a=2, src_b=0, alu_op=10, then WB_ALU.
- **EXEC_I:** src_a=2, src_b=2, alu_op=10, then WB_ALU.
- **ADDR:** src_a=2, src_b=2, alu_op=00. Next state is MEM_RD for a load, MEM_WR for a store; the opcode is latched in DECODE.
- **MEM_RD:** mem_read=1, iord=1. Hold until i_mem_ready, then WB_MEM.
- **MEM_WR:** mem_write=1, iord=1. Hold until i_mem_ready, then FETCH; the store retires.
- **WB_ALU:** reg_write=1, wb_sel=0, then FETCH; retires.
- **WB_MEM:** reg_write=1, wb_sel=1, then FETCH; retires.
- **BRANCH:** src_a=2, src_b=0, alu_op=01, pc_src=1, pc_write=i_branch_taken, then FETCH; retires.
- **TRAP:** o_illegal=1 (sticky). All enables are 0. Stays in TRAP until reset.
- **Defaults:** any output not listed for a state is 0.
- **Opcode latch:** the opcode is latched on the DECODE→next transition. Later changes on i_opcode are ignored.
- **Retire counter:** o_retired increments by 1 on each retiring transition and wraps modulo 2^CNT_W.

## Timing
- **Reset:** state = FETCH, o_retired = 0, o_illegal = 0.
  - Outputs are Moore-decoded, so the FETCH defaults (mem_read=1, src_b=1) are visible during reset.
  - ir_write and pc_write stay 0 while i_rst_n is low.
- **Mealy terms:** only o_ir_write, FETCH o_pc_write (gated by i_mem_ready) and BRANCH o_pc_write (gated by i_branch_taken).
- **Latency with zero-wait memory** (i_mem_ready held at 1):
  - R-type and I-type: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - jal: 3 cycles
- **Wait states:** each low cycle of i_mem_ready in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- **Mid-instruction reset:** returns to FETCH immediately. No register or memory write is issued after reset asserts. The instruction does not retire.
- **Counter wrap:** all-ones + 1 = 0 in the same cycle as the retirement.

## Configuration
MULTICYCLE_CTRL_JAL_EN:
- **Defined:** opcode 1101111 goes to JUMP. JUMP asserts reg_write=1, wb_sel=2, pc_write=1, pc_src=1, then FETCH; retires.
- **Undefined:** 1101111 goes to TRAP, and the JUMP state is not built.

## Structure
- **Shared package (ctrl_pkg):**
  - state encoding
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL)
  - ALU-op codes
  - alu_src_a, alu_src_b and wb_sel encodings
- **Sub-module ctrl_opcode_class:** combinational opcode → next-state class, used in DECODE. The FSM, opcode latch and counter live in the top module.

## Test plan
1. **R-type:** reset, then 0110011 with ready=1 → states FETCH, DECODE, EXEC_R, WB_ALU. reg_write=1 only in cycle 4. o_retired=1.
2. **Load with wait:** 0000011 with ready=0 for 2 cycles in MEM_RD → 7 cycles total. WB_MEM has wb_sel=1. mem_read=1 and iord=1 throughout MEM_RD.
3. **Branch:** 1100011 with taken=1 → pc_write=1, pc_src=1 in cycle 3. With taken=0 → pc_write=0. Both cases retire.
4. **Illegal opcode:** 1110011 → TRAP. o_illegal=1 stays high for 100 cycles, no enables assert, o_retired unchanged. Reset clears it.
5. **Mid-instruction reset:** reset asserted in WB_MEM → reg_write never asserts, state returns to FETCH, o_retired=0.
6. **Counter wrap and JAL:** CNT_W=4, 16 R-types → o_retired wraps 15→0. With the macro defined, 1101111 → reg_write=1, wb_sel=2, pc_write=1 in cycle 3.
